// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrated mux family.
// clog2 never returns 0, so a grant index always has at least one bit.
package arb_mux_pkg;

  localparam int ARB_NUM_CH_MAX = 16;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set req bit at or after ptr, wrapping.
// Purely combinational; ptr must be below N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any_o,
  output logic [W-1:0] win
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    any_o = |req;
    win   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) win = W'(idx);
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin mux, registered output, 1-cycle latency; ready_o drops while the output beat stalls.
// ARB_MUX_LOCK_EN adds lock_i, which keeps priority on the granted channel for bursts.
module rr_arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 32,
  localparam int GNT_W  = clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  input  logic [NUM_CH-1:0]        valid_i,
  output logic [NUM_CH-1:0]        ready_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [GNT_W-1:0]         grant_o
`ifdef ARB_MUX_LOCK_EN
  ,
  input  logic                     lock_i
`endif
);

  logic [GNT_W-1:0] ptr;
  logic [GNT_W-1:0] win;
  logic [GNT_W-1:0] ptr_nxt;
  logic             any;
  logic             load;
  logic             lock;

  rr_pick #(
    .N(NUM_CH),
    .W(GNT_W)
  ) u_pick (
    .req  (valid_i),
    .ptr  (ptr),
    .any_o(any),
    .win  (win)
  );

`ifdef ARB_MUX_LOCK_EN
  assign lock = lock_i;
`else
  assign lock = 1'b0;
`endif

  // Output slot is free or being drained this cycle.
  assign load    = !valid_o || ready_i;
  assign ptr_nxt = lock ? win : ((win == GNT_W'(NUM_CH - 1)) ? '0 : win + 1'b1);
  assign ready_o = (rst_i && load && any) ? (NUM_CH'(1) << win) : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      grant_o <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (any) begin
        data_o  <= data_i[win*DATA_W +: DATA_W];
        valid_o <= 1'b1;
        grant_o <= win;
        ptr     <= ptr_nxt;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
Parametrised N-channel arbitrated multiplexer with a registered output and valid/ready handshaking on every channel. It is the sequential successor of the fixed 2:1 datapath mux. It serves pipelined-CPU paths where several producers share one consumer, for example multiple write-back sources or memory requesters. Arbitration is round-robin, and one beat is accepted per cycle.

Parameters:
NUM_CH, 4, number of input channels; must be >= 2 and need not be a power of 2.
DATA_W, 32, data width per channel in bits.
GNT_W, clog2(NUM_CH), width of the grant index; derived, not overridden.

Ports:
clk_i  input  1  clock; rising edge.
rst_i  input  1  reset; asynchronous, active-low.
data_i  input  NUM_CH*DATA_W  flattened channel data; channel k occupies bits [k*DATA_W +: DATA_W].
valid_i  input  NUM_CH  per-channel request valid.
ready_o  output  NUM_CH  per-channel accept; one-hot or zero.
data_o  output  DATA_W  registered selected data.
valid_o  output  1  output holds a valid beat.
ready_i  input  1  consumer accepts the output beat.
grant_o  output  GNT_W  index of the channel that supplied data_o.
lock_i  input  1  present only with ARB_MUX_LOCK_EN; see Optional Feature.

Behaviour:
- Reset (rst_i=0, asynchronous): valid_o=0, data_o=0, grant_o=0, round-robin pointer ptr=0. ready_o is all zero while rst_i=0. Reset mid-transfer discards the held beat.
- load = !valid_o || ready_i. This is the output register slot free/advancing condition; it is combinational.
- Winner w is the first k with valid_i[k]=1, scanning ptr, ptr+1, ... NUM_CH-1, 0, ... ptr-1.
- ready_o[w]=1 only when load=1 and at least one valid_i is set. All other ready_o bits are 0. ready_o is combinational from valid_i, ptr, valid_o and ready_i.
- On a clock edge with load=1 and a winner: data_o<=data_i[w], valid_o<=1, grant_o<=w, ptr<=(w==NUM_CH-1)?0:w+1.
- On a clock edge with load=1 and no valid_i: valid_o<=0. data_o, grant_o and ptr hold.
- On a clock edge with load=0 (valid_o=1, ready_i=0): data_o, grant_o, valid_o and ptr all hold. ready_o is all zero.
- A channel's transfer occurs when valid_i[k] && ready_o[k]. Producers must hold data/valid until that transfer occurs. The block does not check this.
- Latency: 1 cycle from input transfer to valid_o. Throughput: 1 beat/cycle when ready_i=1.
- Simultaneous output drain and new acceptance in the same cycle is required.
- Wrap-around: for non-power-of-2 NUM_CH, ptr never exceeds NUM_CH-1.
- A sole requester is granted every cycle with no bubble.
- Fairness: any continuously valid channel is granted within NUM_CH accepted beats.

Optional Feature:
- Macro: ARB_MUX_LOCK_EN.
- Defined: lock_i port exists. On an accepted beat with lock_i=1, ptr<=w instead of w+1, so the same channel keeps priority for multi-beat bursts. If that channel then drops valid_i, normal scanning from ptr applies.
- Undefined: lock_i port is absent and ptr always advances to w+1.

Decomposition:
- Shared package arb_mux_pkg: clog2 function (returns >= 1); constant ARB_NUM_CH_MAX=16.
- One sub-module rr_pick: combinational priority picker. Inputs are req vector and ptr. Outputs are any_o and winner index. It is reused later by other arbiters.
- The top level holds the output register, ptr register and handshake logic.

Test Plan (NUM_CH=4, DATA_W=8 unless stated):
1. Drive rst_i low mid-stream with valid_o=1, data_o=0x12 -> valid_o=0, data_o=0x00, grant_o=0, ready_o=4'b0000 immediately, without waiting for a clock edge.
2. All valid_i=4'b1111, data ch k=0x10+k, ready_i=1 -> data_o sequence 0x10,0x11,0x12,0x13,0x10, and grant_o sequence 0,1,2,3,0, on consecutive cycles.
3. After data_o=0x11 hold ready_i=0 for 3 cycles -> data_o=0x11 and grant_o=1 stable, ready_o=0000. Release ready_i -> next beat 0x12 from channel 2 the following cycle.
4. Only valid_i[3]=1 continuously with ready_i=1 -> grant_o=3 every cycle, ready_o=4'b1000 every cycle, no bubbles.
5. NUM_CH=3, all valid, ready_i=1 -> grant_o sequence 0,1,2,0,1, so ptr wraps at 2.
6. valid_i[1] and valid_i[2] set, lock_i=1 at channel-1 grant -> with ARB_MUX_LOCK_EN, channel 1 is granted again; without the macro, channel 2 is granted.
